fifo_wr_arb: RTL
================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width of every requester and of the FIFO write port.
REQ-002 The block SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-003 The block SHALL have parameter BURST, default 2, meaning maximum transfers per grant (1..15).
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req  input  N  per-requester valid; bit i means requester i holds a word on its din slice.
REQ-007 The block SHALL have port din  input  N*DW  requester data; slice i = din[i*DW +: DW].
REQ-008 The block SHALL have port ack  output  N  one-hot-or-zero; bit i high means requester i's word is written this cycle.
REQ-009 The block SHALL have port fifo_wen  output  1  write enable to downstream FIFO.
REQ-010 The block SHALL have port fifo_data  output  DW  write data to downstream FIFO.
REQ-011 The block SHALL have port fifo_full  input  1  downstream FIFO full flag.
REQ-012 The block SHALL have port grant_id  output  $clog2(N)  index of current owner; 0 when idle.
REQ-013 The block SHALL have port busy  output  1  high while a grant is held.

Function
REQ-014 States SHALL be IDLE and GRANT only.
REQ-015 IDLE: if any req bit is high and fifo_full is low, the block SHALL select the first requesting index scanning last+1, last+2, ... modulo N, register it as owner, set last=owner, clear burst count, and enter GRANT at the next edge.
REQ-016 IDLE with no req, or with fifo_full high, SHALL remain IDLE with no state change.
REQ-017 GRANT: fifo_wen SHALL equal req[owner] AND NOT fifo_full, combinationally.
REQ-018 ack[owner] SHALL equal fifo_wen; all other ack bits SHALL be 0; in IDLE all ack bits SHALL be 0.
REQ-019 fifo_data SHALL equal din slice of owner in GRANT, and 0 in IDLE.
REQ-020 Each cycle with fifo_wen high SHALL increment burst count by 1.
REQ-021 GRANT SHALL return to IDLE at the edge ending a transfer that brings the count to BURST, or at the first edge where req[owner] is low.
REQ-022 GRANT with req[owner] high and fifo_full high SHALL stall: no write, no ack, count and owner held, no timeout.
REQ-023 Latency: req seen in IDLE at cycle t SHALL produce earliest ack at cycle t+1; one IDLE arbitration cycle SHALL separate consecutive grants.
REQ-024 The block SHALL never assert fifo_wen while fifo_full is high.
REQ-025 Requester changes of req/din for non-owners SHALL have no effect during GRANT.
REQ-026 grant_id SHALL equal owner and busy SHALL be 1 in GRANT; both 0 in IDLE.

Reset
REQ-027 rst high SHALL force IDLE, owner=0, burst count=0, last=N-1 immediately, without waiting for clk.
REQ-028 While rst is high: ack=0, fifo_wen=0, fifo_data=0, grant_id=0, busy=0.
REQ-029 rst asserted mid-burst SHALL abort the grant; the transfer in that cycle SHALL NOT occur; first grant after release SHALL scan from requester 0.

Verification (N=4, BURST=2, DW=8)
REQ-030 Reset: rst pulse, req=0 -> all outputs 0; then req=4'b1111 -> first grant_id=0.
REQ-031 Single requester: only req[2]=1, words 8'hA1,8'hA2,8'hA3 presented after each ack -> FIFO receives A1,A2 on cycles t+1,t+2, IDLE at t+3, A3 at t+4; grant_id=2 throughout grants.
REQ-032 Round-robin: req=4'b1111 held, distinct data per requester -> grant order 0,1,2,3,0, two writes each, one idle cycle between grants.
REQ-033 Backpressure: owner 1 after first write, fifo_full=1 for 3 cycles -> fifo_wen=0, ack=0, busy=1, grant_id=1 for 3 cycles; second write on first cycle fifo_full=0.
REQ-034 Early release: owner 3 drops req after one write -> IDLE next edge; with req[0] and req[1] high next grant goes to 0.
REQ-035 Reset mid-burst: rst asserted during owner 2's first transfer cycle -> ack and fifo_wen fall within same cycle, busy=0; after release with req=4'b0110 next grant_id=1.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Requester/FIFO-write bundle shared by the arbiter and its environment.
interface fifo_wr_arb_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N*DW-1:0] din;
  logic [N-1:0]    ack;
  logic            fifo_wen;
  logic [DW-1:0]   fifo_data;
  logic            fifo_full;
  logic [IW-1:0]   grant_id;
  logic            busy;

  // Environment side: requesters plus the downstream FIFO full flag.
  modport master (
    output req, din, fifo_full,
    input  ack, fifo_wen, fifo_data, grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req, din, fifo_full,
    output ack, fifo_wen, fifo_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting N requesters bursts of up to BURST writes
// into one downstream FIFO write port.
module fifo_wr_arb #(
  parameter int unsigned DW    = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned BURST = 2
) (
  input  logic         clk,
  input  logic         rst,
  fifo_wr_arb_if.slave bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(BURST + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] owner;
  logic [IW-1:0] owner_nxt;
  logic [IW-1:0] last;
  logic [IW-1:0] last_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic          any_req_c;
  logic          pick_found_c;
  logic [IW-1:0] pick_c;
  logic          owner_req_c;
  logic          wen_c;
  logic          last_xfer_c;

  // Round-robin pick: first requester found scanning last+1, last+2, ... mod N.
  always_comb begin
    pick_found_c = 1'b0;
    pick_c       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      logic [IW-1:0] idx;
      idx = IW'((32'(last) + k) % N);
      if (!pick_found_c && bus.req[idx]) begin
        pick_found_c = 1'b1;
        pick_c       = idx;
      end
    end
  end

  // Shared qualifiers for the current owner's transfer.
  always_comb begin
    any_req_c   = |bus.req;
    owner_req_c = bus.req[owner];
    wen_c       = (state == GRANT) && owner_req_c && !bus.fifo_full;
    last_xfer_c = wen_c && ((32'(cnt) + 32'd1) == BURST);
  end

  // State register; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Owner, round-robin pointer and burst counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= '0;
      last  <= LAST_RST;
      cnt   <= '0;
    end else begin
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, count writes and release in GRANT.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        // Arbitration waits out a full FIFO so a grant never starts stalled.
        if (any_req_c && !bus.fifo_full && pick_found_c) begin
          state_nxt = GRANT;
          owner_nxt = pick_c;
          last_nxt  = pick_c;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (wen_c) begin
          cnt_nxt = cnt + CW'(1);
        end
        // A full FIFO with the owner still requesting simply holds everything.
        if (!owner_req_c || last_xfer_c) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs: owner's word steered to the FIFO while granted, all zero in IDLE.
  always_comb begin
    bus.ack       = '0;
    bus.fifo_wen  = 1'b0;
    bus.fifo_data = '0;
    bus.grant_id  = '0;
    bus.busy      = 1'b0;
    if (state == GRANT) begin
      bus.busy       = 1'b1;
      bus.grant_id   = owner;
      bus.fifo_wen   = wen_c;
      bus.fifo_data  = bus.din[32'(owner) * DW +: DW];
      bus.ack[owner] = wen_c;
    end
  end

endmodule
